alu_result_fifo: RTL and testbench

//   Downstream stage of ALU_8bit. Captures each ALU result with its opcode tag and

---
 rtl/alu_result_fifo.sv | 187 ++++++++++++++++++
 tb/tb_alu_result_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Purpose:
//   Sits behind ALU_8bit and buffers each ALU result together with the opcode
//   that produced it and the four status flags {C,O,Z,N}. The buffer is a small
//   first-word-fall-through FIFO with valid/ready handshakes on both sides, so
//   a slow consumer (register writeback, display) can stall without losing
//   results. Two sticky bits remember whether any accepted result carried or
//   overflowed since software last cleared them.
//
// Ports:
//   clk           in   1        single clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   in_valid_i    in   1        ALU output entry presented
//   in_ready_o    out  1        FIFO can accept an entry this cycle
//   in_result_i   in   WIDTH    ALU result
//   in_opcode_i   in   OPW      opcode that produced in_result_i
//   in_cf_i       in   1        carry flag
//   in_of_i       in   1        overflow flag
//   in_zf_i       in   1        zero flag
//   in_nf_i       in   1        negative flag
//   out_valid_o   out  1        head entry available
//   out_ready_i   in   1        consumer takes head entry
//   out_result_o  out  WIDTH    head result (0 when empty)
//   out_opcode_o  out  OPW      head opcode tag (0 when empty)
//   out_flags_o   out  4        head flags {C,O,Z,N} (0 when empty)
//   count_o       out  AW+1     entries stored, 0..DEPTH
//   sticky_cf_o   out  1        set by any accepted entry with carry
//   sticky_of_o   out  1        set by any accepted entry with overflow
//   clr_sticky_i  in   1        synchronous clear of both sticky bits
// -----------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_result_i,
   input  logic [OPW-1:0]               in_opcode_i,
   input  logic                         in_cf_i,
   input  logic                         in_of_i,
   input  logic                         in_zf_i,
   input  logic                         in_nf_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_result_o,
   output logic [OPW-1:0]               out_opcode_o,
   output logic [3:0]                   out_flags_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         sticky_cf_o,
   output logic                         sticky_of_o,
   input  logic                         clr_sticky_i
);

   localparam int AW = $clog2(DEPTH);   // storage index width
   localparam int PW = AW + 1;          // pointer width, one wrap bit extra
   localparam int EW = WIDTH + OPW + 4; // packed entry width

   // Occupancy class, decoded from the pointers every cycle. There is no
   // separate state register: the pointers already are the state.
   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_PARTIAL = 2'd1,
      FILL_FULL    = 2'd2
   } fill_e;

   fill_e              fill_state;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               sticky_cf_q, sticky_cf_d;
   logic               sticky_of_q, sticky_of_d;

   logic [AW-1:0]      wr_idx;
   logic [AW-1:0]      rd_idx;
   logic               ptr_empty;
   logic               ptr_full;
   logic               push;
   logic               pop;

   logic [EW-1:0]      in_entry;
   logic [EW-1:0]      head_entry;

   // Storage is intentionally left out of reset; only the pointers say what
   // is meaningful.
   logic [EW-1:0]      mem_q [DEPTH];

   // --------------------------------------------------------------------------
   // Pointer decode
   // --------------------------------------------------------------------------
   assign wr_idx    = wr_ptr_q[AW-1:0];
   assign rd_idx    = rd_ptr_q[AW-1:0];
   assign ptr_empty = (wr_ptr_q == rd_ptr_q);
   // Same slot but opposite lap means the writer is a full lap ahead.
   assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   always_comb begin
      fill_state = FILL_PARTIAL;
      if (ptr_empty) begin
         fill_state = FILL_EMPTY;
      end else if (ptr_full) begin
         fill_state = FILL_FULL;
      end
   end

   // Ready depends only on registered state, so a full FIFO refuses a push
   // even while the consumer is popping in the same cycle.
   assign in_ready_o  = (fill_state != FILL_FULL);
   assign out_valid_o = (fill_state != FILL_EMPTY);

   assign push = in_valid_i  && in_ready_o;
   assign pop  = out_valid_o && out_ready_i;

   // Pointer difference modulo 2*DEPTH gives the occupancy 0..DEPTH directly.
   assign count_o = wr_ptr_q - rd_ptr_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      sticky_cf_d = sticky_cf_q;
      sticky_of_d = sticky_of_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      // A flag arriving in the same cycle as a clear survives the clear.
      sticky_cf_d = (clr_sticky_i ? 1'b0 : sticky_cf_q) | (push & in_cf_i);
      sticky_of_d = (clr_sticky_i ? 1'b0 : sticky_of_q) | (push & in_of_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sticky_cf_q <= 1'b0;
         sticky_of_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         sticky_cf_q <= sticky_cf_d;
         sticky_of_q <= sticky_of_d;
      end
   end

   assign sticky_cf_o = sticky_cf_q;
   assign sticky_of_o = sticky_of_q;

   // --------------------------------------------------------------------------
   // Storage
   // --------------------------------------------------------------------------
   assign in_entry = {in_result_i, in_opcode_i, in_cf_i, in_of_i, in_zf_i, in_nf_i};

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_idx] <= in_entry;
      end
   end

   // Fall-through read: the head slot is visible combinationally, so an entry
   // written into an empty FIFO appears on the outputs one cycle later.
   assign head_entry = mem_q[rd_idx];

   // Outputs are forced to zero while empty so stale storage never leaks out,
   // including straight after an asynchronous reset.
   always_comb begin
      out_result_o = '0;
      out_opcode_o = '0;
      out_flags_o  = '0;
      if (out_valid_o) begin
         out_result_o = head_entry[EW-1 -: WIDTH];
         out_opcode_o = head_entry[3+OPW -: OPW];
         out_flags_o  = head_entry[3:0];
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

   localparam int WIDTH = 8;
   localparam int OPW   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [OPW-1:0]   in_opcode;
   logic             in_cf, in_of, in_zf, in_nf;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [OPW-1:0]   out_opcode;
   logic [3:0]       out_flags;
   logic [CW-1:0]    count;
   logic             sticky_cf, sticky_of;
   logic             clr_sticky;

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue of {result, opcode, C, O, Z, N} plus two bits.
   logic [WIDTH+OPW+3:0] mq [$];
   logic                 m_scf, m_sof;

   // Expected observables derived from the model.
   logic [WIDTH-1:0] e_res;
   logic [OPW-1:0]   e_op;
   logic [3:0]       e_flg;
   logic [CW-1:0]    e_cnt;
   logic             e_ov, e_ir;

   alu_result_fifo #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_result_i  (in_result),
      .in_opcode_i  (in_opcode),
      .in_cf_i      (in_cf),
      .in_of_i      (in_of),
      .in_zf_i      (in_zf),
      .in_nf_i      (in_nf),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_result_o (out_result),
      .out_opcode_o (out_opcode),
      .out_flags_o  (out_flags),
      .count_o      (count),
      .sticky_cf_o  (sticky_cf),
      .sticky_of_o  (sticky_of),
      .clr_sticky_i (clr_sticky)
   );

   always #5 clk = ~clk;

   // Recompute what the outputs should show from the model contents.
   task automatic model_expect();
      e_cnt = CW'(mq.size());
      e_ov  = (mq.size() != 0);
      e_ir  = (mq.size() != DEPTH);
      if (mq.size() != 0) begin
         e_res = mq[0][WIDTH+OPW+3 -: WIDTH];
         e_op  = mq[0][OPW+3 -: OPW];
         e_flg = mq[0][3:0];
      end else begin
         e_res = '0;
         e_op  = '0;
         e_flg = '0;
      end
   endtask

   // One clock: decide push/pop from the model, advance the model, settle.
   task automatic tick();
      bit push, pop;
      push = in_valid && (mq.size() != DEPTH);
      pop  = out_ready && (mq.size() != 0);
      @(posedge clk);
      if (pop) begin
         $display("[%0t] pop  result=%02h op=%0h flags=%04b", $time,
                  mq[0][WIDTH+OPW+3 -: WIDTH], mq[0][OPW+3 -: OPW], mq[0][3:0]);
         void'(mq.pop_front());
      end
      if (push) begin
         $display("[%0t] push result=%02h op=%0h flags=%b%b%b%b", $time,
                  in_result, in_opcode, in_cf, in_of, in_zf, in_nf);
         mq.push_back({in_result, in_opcode, in_cf, in_of, in_zf, in_nf});
      end
      m_scf = (clr_sticky ? 1'b0 : m_scf) | (push & in_cf);
      m_sof = (clr_sticky ? 1'b0 : m_sof) | (push & in_of);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [WIDTH-1:0] r, input logic [OPW-1:0] op,
                         input logic [3:0] f);
      in_valid  = v;
      in_result = r;
      in_opcode = op;
      {in_cf, in_of, in_zf, in_nf} = f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, '0, '0, '0);
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      mq.delete();
      m_scf = 1'b0;
      m_sof = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_result !== '0 || out_opcode !== '0 || out_flags !== '0) begin
         errors++; $display("FAIL reset_out_data got=%h/%h/%b exp=0", out_result, out_opcode, out_flags); end
      checks++; if (sticky_cf !== 1'b0 || sticky_of !== 1'b0) begin
         errors++; $display("FAIL reset_sticky got=%b%b exp=00", sticky_cf, sticky_of); end
   endtask

   task automatic test_single_push();
      set_in(1'b1, 8'h7F, 4'h0, 4'b0100);
      out_ready = 1'b0;
      tick();
      set_in(1'b0, '0, '0, '0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_result !== 8'h7F) begin errors++; $display("FAIL single_result got=%h exp=7f", out_result); end
      checks++; if (out_flags !== 4'b0100) begin errors++; $display("FAIL single_flags got=%b exp=0100", out_flags); end
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
      checks++; if (sticky_of !== 1'b1) begin errors++; $display("FAIL single_sticky_of got=%b exp=1", sticky_of); end
      // Head must hold while stalled.
      tick();
      checks++; if (out_result !== 8'h7F || count !== CW'(1)) begin
         errors++; $display("FAIL single_stall got=%h/%0d exp=7f/1", out_result, count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_result !== '0) begin
         errors++; $display("FAIL single_drain got=%b/%h exp=0/00", out_valid, out_result); end
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         set_in(1'b1, WIDTH'(i), OPW'(i), 4'b0010);
         tick();
      end
      checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      // Push against a full FIFO while popping: pop happens, push is refused.
      set_in(1'b1, 8'h05, 4'h5, 4'b0000);
      out_ready = 1'b1;
      tick();
      set_in(1'b0, '0, '0, '0);
      checks++; if (count !== CW'(DEPTH-1)) begin errors++; $display("FAIL full_nopass_count got=%0d exp=%0d", count, DEPTH-1); end
      for (int v = 2; v <= DEPTH; v++) begin
         checks++; if (out_valid !== 1'b1 || out_result !== WIDTH'(v)) begin
            errors++; $display("FAIL full_order got=%b/%h exp=1/%h", out_valid, out_result, WIDTH'(v)); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (count !== '0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL full_drained got=%0d/%b exp=0/0", count, out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      set_in(1'b1, 8'd0, 4'h1, 4'b0000);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 3*DEPTH; i++) begin
         checks++; if (out_result !== WIDTH'(i) || count !== CW'(1)) begin
            errors++; $display("FAIL b2b_head got=%h/%0d exp=%h/1", out_result, count, WIDTH'(i)); end
         if (i < 3*DEPTH-1) set_in(1'b1, WIDTH'(i+1), 4'h1, 4'b0000);
         else               set_in(1'b0, '0, '0, '0);
         tick();
      end
      out_ready = 1'b0;
      checks++; if (count !== '0) begin errors++; $display("FAIL b2b_final_count got=%0d exp=0", count); end
   endtask

   task automatic test_sticky();
      clr_sticky = 1'b1;
      tick();
      checks++; if (sticky_cf !== 1'b0 || sticky_of !== 1'b0) begin
         errors++; $display("FAIL sticky_clear got=%b%b exp=00", sticky_cf, sticky_of); end
      set_in(1'b1, 8'h80, 4'h2, 4'b1000);
      tick();
      set_in(1'b0, '0, '0, '0);
      checks++; if (sticky_cf !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_cf); end
      tick();
      clr_sticky = 1'b0;
      checks++; if (sticky_cf !== 1'b0) begin errors++; $display("FAIL sticky_cleared got=%b exp=0", sticky_cf); end
      // Popping must not touch sticky bits.
      set_in(1'b1, 8'h01, 4'h3, 4'b1000);
      tick();
      set_in(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      checks++; if (sticky_cf !== 1'b1 || count !== '0) begin
         errors++; $display("FAIL sticky_pop got=%b/%0d exp=1/0", sticky_cf, count); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 8'hC0 + WIDTH'(i), 4'h9, 4'b0001);
         tick();
      end
      set_in(1'b0, '0, '0, '0);
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
      #2 rst = 1'b1;
      #1;
      mq.delete();
      m_scf = 1'b0;
      m_sof = 1'b0;
      checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL areset_now got cnt=%0d ov=%b ir=%b exp 0/0/1", count, out_valid, in_ready); end
      checks++; if (out_result !== '0 || out_flags !== '0 || sticky_cf !== 1'b0) begin
         errors++; $display("FAIL areset_data got=%h/%b/%b exp=00/0000/0", out_result, out_flags, sticky_cf); end
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      set_in(1'b1, 8'hAA, 4'h6, 4'b0011);
      tick();
      set_in(1'b0, '0, '0, '0);
      checks++; if (out_valid !== 1'b1 || out_result !== 8'hAA || out_opcode !== 4'h6 || count !== CW'(1)) begin
         errors++; $display("FAIL areset_after got=%b/%h/%h/%0d exp=1/aa/6/1", out_valid, out_result, out_opcode, count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         model_expect();
         checks++; if (out_valid !== e_ov || in_ready !== e_ir || count !== e_cnt) begin
            errors++; $display("FAIL rand_status cyc=%0d got ov=%b ir=%b cnt=%0d exp ov=%b ir=%b cnt=%0d",
                               i, out_valid, in_ready, count, e_ov, e_ir, e_cnt); end
         checks++; if (out_result !== e_res || out_opcode !== e_op || out_flags !== e_flg) begin
            errors++; $display("FAIL rand_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b",
                               i, out_result, out_opcode, out_flags, e_res, e_op, e_flg); end
         checks++; if (sticky_cf !== m_scf || sticky_of !== m_sof) begin
            errors++; $display("FAIL rand_sticky cyc=%0d got=%b%b exp=%b%b", i, sticky_cf, sticky_of, m_scf, m_sof); end
         // Alternate bias so the FIFO spends time both near full and near empty.
         set_in(($urandom_range(0, 3) != 0), WIDTH'($urandom), OPW'($urandom), 4'($urandom));
         out_ready  = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 7) == 0);
         tick();
      end
      set_in(1'b0, '0, '0, '0);
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_full();
      test_back_to_back();
      test_sticky();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
